// File: rtl/csel_sub_pipe_pkg.sv
// +-----------------------------------------------------------------------+
// | csel_sub_pipe_pkg: shared sizing and stage-register type              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package csel_sub_pipe_pkg;

   localparam int DEF_OPERAND_SIZE = 16;
   localparam int DEF_BLOCK_SIZE   = 4;

   // carry is the true adder carry (not borrow) out of the block this stage processed
   typedef struct packed {
      logic                        valid;
      logic                        carry;
      logic [DEF_OPERAND_SIZE-1:0] diff;
      logic [DEF_OPERAND_SIZE-1:0] a;
      logic [DEF_OPERAND_SIZE-1:0] b;
   } stage_reg_t;

   // carry=1 makes an idle output report Bout=0
   localparam stage_reg_t STAGE_IDLE = '{valid: 1'b0, carry: 1'b1, diff: '0, a: '0, b: '0};

endpackage

`default_nettype wire

// File: rtl/csel_sub_stage.sv
// +-----------------------------------------------------------------------+
// | csel_sub_stage: one carry-select block, both carry-ins precomputed    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module csel_sub_stage
   import csel_sub_pipe_pkg::*;
#(
   parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
   input  logic [BLOCK_SIZE-1:0] a_blk,
   input  logic [BLOCK_SIZE-1:0] b_blk,
   input  logic                  cin,
   output logic [BLOCK_SIZE-1:0] diff_blk,
   output logic                  cout
);

   logic [BLOCK_SIZE:0] w_sum0;
   logic [BLOCK_SIZE:0] w_sum1;

   // subtraction as a + ~b; the select picks the +1 variant when carry-in is set
   assign w_sum0 = {1'b0, a_blk} + {1'b0, ~b_blk};
   assign w_sum1 = {1'b0, a_blk} + {1'b0, ~b_blk} + (BLOCK_SIZE+1)'(1);

   assign {cout, diff_blk} = cin ? w_sum1 : w_sum0;

endmodule

`default_nettype wire

// File: rtl/csel_sub_pipe.sv
// +-----------------------------------------------------------------------+
// | csel_sub_pipe: pipelined carry-select subtractor, one block per stage |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module csel_sub_pipe
   import csel_sub_pipe_pkg::*;
#(
   parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
   parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPERAND_SIZE-1:0] A,
   input  logic [OPERAND_SIZE-1:0] B,
   input  logic                    Bin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OPERAND_SIZE-1:0] Dout,
   output logic                    Bout,
   output logic                    Ovf
);

   localparam int NUM_STAGES = OPERAND_SIZE / BLOCK_SIZE;
   localparam int MSB        = OPERAND_SIZE - 1;

   // stage registers are typed from the package, so the operand width must match it
   if ((OPERAND_SIZE % BLOCK_SIZE) != 0 || OPERAND_SIZE != DEF_OPERAND_SIZE) begin : g_cfg_check
      $error("csel_sub_pipe: unsupported OPERAND_SIZE/BLOCK_SIZE combination");
   end

   stage_reg_t                             r_stg [NUM_STAGES];
   stage_reg_t                             w_src [NUM_STAGES];
   logic [NUM_STAGES-1:0][BLOCK_SIZE-1:0]  w_blk_diff;
   logic [NUM_STAGES-1:0]                  w_blk_cout;
   logic                                   w_advance;

   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   always_comb begin
      w_src[0]       = STAGE_IDLE;
      w_src[0].valid = in_valid;
      w_src[0].carry = ~Bin;
      w_src[0].diff  = '0;
      w_src[0].a     = A;
      w_src[0].b     = B;
      for (int k = 1; k < NUM_STAGES; k++) begin
         w_src[k] = r_stg[k-1];
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      csel_sub_stage #(
         .BLOCK_SIZE (BLOCK_SIZE)
      ) u_stage (
         .a_blk    (w_src[k].a[k*BLOCK_SIZE +: BLOCK_SIZE]),
         .b_blk    (w_src[k].b[k*BLOCK_SIZE +: BLOCK_SIZE]),
         .cin      (w_src[k].carry),
         .diff_blk (w_blk_diff[k]),
         .cout     (w_blk_cout[k])
      );
   end

   // every stage shifts in lock-step, so a stalled output freezes the whole pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_stg[k] <= STAGE_IDLE;
         end
      end else if (w_advance) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_stg[k]                                <= w_src[k];
            r_stg[k].carry                          <= w_blk_cout[k];
            r_stg[k].diff[k*BLOCK_SIZE +: BLOCK_SIZE] <= w_blk_diff[k];
         end
      end
   end

   assign out_valid = r_stg[NUM_STAGES-1].valid;
   assign Dout      = r_stg[NUM_STAGES-1].diff;
   assign Bout      = ~r_stg[NUM_STAGES-1].carry;
   assign Ovf       = (r_stg[NUM_STAGES-1].a[MSB] != r_stg[NUM_STAGES-1].b[MSB]) &&
                      (r_stg[NUM_STAGES-1].diff[MSB] != r_stg[NUM_STAGES-1].a[MSB]);

endmodule

`default_nettype wire

// File: tb/tb_csel_sub_pipe.sv
// +-----------------------------------------------------------------------+
// | tb_csel_sub_pipe: directed vector table plus stall and reset sequences |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_csel_sub_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Dout;
   logic        Bout;
   logic        Ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bout;
      logic        ovf;
   } vec_t;

   vec_t vecs [10];

   logic [15:0] sa   [8];
   logic [15:0] sb   [8];
   logic        sbin [8];

   csel_sub_pipe #(
      .OPERAND_SIZE (16),
      .BLOCK_SIZE   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Dout      (Dout),
      .Bout      (Bout),
      .Ovf       (Ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference: {bout, ovf, diff}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      logic [16:0] t;
      logic        ov;
      t  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
      ov = (a[15] != b[15]) && (t[15] != a[15]);
      return {t[16], ov, t[15:0]};
   endfunction

   task automatic run_one(input vec_t v, input string tag);
      int cnt;
      @(negedge clk);
      A = v.a; B = v.b; Bin = v.bin;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      cnt = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      check({tag, "_latency"}, cnt, 32'd4);
      check({tag, "_dout"}, {16'd0, Dout}, {16'd0, v.d});
      check({tag, "_bout"}, {31'd0, Bout}, {31'd0, v.bout});
      check({tag, "_ovf"},  {31'd0, Ovf},  {31'd0, v.ovf});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] exp;
      int sent, rcv, cyc;

      vecs[0] = '{a: 16'h0005, b: 16'h0003, bin: 1'b0, d: 16'h0002, bout: 1'b0, ovf: 1'b0};
      vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, d: 16'hFFFF, bout: 1'b1, ovf: 1'b0};
      vecs[2] = '{a: 16'h1000, b: 16'h0FFF, bin: 1'b1, d: 16'h0000, bout: 1'b0, ovf: 1'b0};
      vecs[3] = '{a: 16'h8000, b: 16'h0001, bin: 1'b0, d: 16'h7FFF, bout: 1'b0, ovf: 1'b1};
      vecs[4] = '{a: 16'h7FFF, b: 16'hFFFF, bin: 1'b0, d: 16'h8000, bout: 1'b1, ovf: 1'b1};
      vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, bin: 1'b1, d: 16'hFFFF, bout: 1'b1, ovf: 1'b0};
      vecs[6] = '{a: 16'h1234, b: 16'h1234, bin: 1'b0, d: 16'h0000, bout: 1'b0, ovf: 1'b0};
      vecs[7] = '{a: 16'h0000, b: 16'h0000, bin: 1'b1, d: 16'hFFFF, bout: 1'b1, ovf: 1'b0};
      vecs[8] = '{a: 16'h8000, b: 16'h7FFF, bin: 1'b0, d: 16'h0001, bout: 1'b0, ovf: 1'b1};
      vecs[9] = '{a: 16'hABCD, b: 16'h1234, bin: 1'b0, d: 16'h9999, bout: 1'b0, ovf: 1'b0};

      for (int i = 0; i < 8; i++) begin
         sa[i]   = 16'($urandom);
         sb[i]   = 16'($urandom);
         sbin[i] = 1'($urandom_range(0, 1));
      end

      // reset state
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Bin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_dout", {16'd0, Dout}, 32'd0);
      check("rst_bout", {31'd0, Bout}, 32'd0);
      check("rst_ovf",  {31'd0, Ovf},  32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

      // directed table, one transfer at a time
      for (int i = 0; i < 10; i++) begin
         run_one(vecs[i], $sformatf("vec%0d", i));
      end

      // back-to-back stream with a 3-cycle output stall
      sent = 0; rcv = 0; cyc = 0;
      while (rcv < 8 && cyc < 100) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 6);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            A = sa[sent]; B = sb[sent]; Bin = sbin[sent];
         end
         #1;
         if (out_valid && !out_ready)
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         if (out_valid) begin
            exp = model(sa[rcv], sb[rcv], sbin[rcv]);
            check($sformatf("stream%0d_dout", rcv), {16'd0, Dout}, {16'd0, exp[15:0]});
            check($sformatf("stream%0d_bout", rcv), {31'd0, Bout}, {31'd0, exp[17]});
            check($sformatf("stream%0d_ovf",  rcv), {31'd0, Ovf},  {31'd0, exp[16]});
            if (out_ready) rcv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         cyc++;
      end
      check("stream_count", rcv, 32'd8);
      check("stream_cycles", {31'd0, cyc <= 16}, 32'd1);

      // fill, hold result at the output, then reset mid-flight
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A = vecs[i].a; B = vecs[i].b; Bin = vecs[i].bin;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("fill_out_valid", {31'd0, out_valid}, 32'd1);
      check("fill_dout", {16'd0, Dout}, {16'd0, vecs[0].d});
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_dout", {16'd0, Dout}, 32'd0);
      check("midrst_bout", {31'd0, Bout}, 32'd0);
      check("midrst_ovf",  {31'd0, Ovf},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle%0d", i), {31'd0, out_valid}, 32'd0);
      end
      run_one(vecs[4], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
